aes_enc_round_sequencer: RTL
============================

// Module: aes_enc_round_sequencer
// PURPOSE
//  Iterative AES-128 encryption controller. Accepts a plaintext and cipher key over a
//  valid/ready handshake and performs the initial AddRoundKey (whitening). It then runs
//  NR passes through the external single-round datapath (SubBytes/ShiftRows/MixColumns/
//  AddRoundKey), generating each round key on the fly. The ciphertext is returned over a
//  valid/ready handshake. Sits between the bus-side request logic and the round datapath.
// PARAMETERS
//  NR         10   number of rounds (AES-128); round counter width = $clog2(NR+1)
//  ROUND_LAT   1   cycles from o_round_valid to i_round_out being valid; must be >= 1
// PORTS
//  i_clk          in   1    clock, all state updates on rising edge
//  i_rst          in   1    synchronous reset, active-high
//  i_start_valid  in   1    request valid
//  o_start_ready  out  1    request accepted when i_start_valid && o_start_ready
//  i_plaintext    in   128  plaintext block, sampled on accept
//  i_key          in   128  cipher key, sampled on accept
//  o_round_valid  out  1    one-cycle issue strobe to the round datapath
//  o_round_in     out  128  state presented to the round datapath
//  o_round_key    out  128  round key presented to the round datapath
//  o_last_round   out  1    final round: datapath bypasses MixColumns
//  i_round_out    in   128  datapath result, sampled ROUND_LAT cycles after the issue cycle
//  o_ct_valid     out  1    ciphertext valid
//  i_ct_ready     in   1    ciphertext consumed when o_ct_valid && i_ct_ready
//  o_ciphertext   out  128  ciphertext block
//  o_busy         out  1    high in any state other than IDLE
// BEHAVIOUR
//  - Reset (i_rst=1 at an edge): FSM->IDLE; state/key regs, round ctr, latency ctr cleared;
//    rcon<=8'h01. All outputs 0 except o_start_ready, which is 1 in IDLE.
//  - FSM: IDLE -> ISSUE -> WAIT -> (ISSUE | DONE) -> IDLE.
//  - IDLE: o_start_ready=1. On accept at edge T: state_reg<=pt^key;
//    key_reg<=key_step(key,8'h01); rcon<=8'h02; round<=1; FSM->ISSUE.
//  - ISSUE (1 cycle): o_round_valid=1; lat_cnt<=ROUND_LAT-1; FSM->WAIT.
//  - o_round_in=state_reg, o_round_key=key_reg, o_last_round=(round==NR); these are stable
//    from ISSUE until the capture edge.
//  - WAIT: if lat_cnt!=0, decrement. At lat_cnt==0, capture state_reg<=i_round_out.
//    If round==NR: FSM->DONE.
//    Else: round++, key_reg<=key_step(key_reg,rcon), rcon<=xtime(rcon) (0x80->0x1B), FSM->ISSUE.
//  - rcon consumed per round: 01 02 04 08 10 20 40 80 1B 36.
//  - Latency: ISSUE of round r at T+1+(r-1)*(ROUND_LAT+1). o_ct_valid first high at
//    T+1+NR*(ROUND_LAT+1); with defaults, T+21.
//  - DONE: o_ct_valid=1 and o_ciphertext=state_reg, held stable until i_ct_ready. On the
//    handshake edge: FSM->IDLE, o_ct_valid->0. No new request is accepted in that same cycle.
//  - o_ciphertext is 0 outside DONE. o_round_* are 0 in IDLE and DONE.
//  - i_start_valid outside IDLE is ignored. Inputs are not re-sampled mid-operation.
//  - i_rst mid-operation: abort immediately. Any datapath result still in flight is ignored;
//    the datapath is not flushed by this block.
//  - key_step(k,rc) = standard AES-128 expansion of one 128-bit round key:
//    w0'=w0^SubWord(RotWord(w3))^{rc,24'h0}; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'.
//    Byte order is big-endian (byte 0 = bits [127:120]).
// STRUCTURE
//  - Package aes_pkg: FSM state enum (IDLE, ISSUE, WAIT, DONE); RCON_INIT=8'h01;
//    functions xtime(), sbox(), sub_word(), rot_word().
//  - Sub-module aes_key_step: combinational, in 128b key + 8b rcon, out next round key.
//    This block instantiates one copy.
//  - Everything else (FSM, counters, state/key regs) lives in this module.
// TESTING (bench drives a cycle-accurate round-datapath model with ROUND_LAT delay)
//  - FIPS-197 App.B: key 2b7e1516..09cf4f3c, pt 3243f6a8..e0370734 -> ct 3925841d02dc09fbdc118597196a0b32;
//    first o_round_key=a0fafe1788542cb123a339392a6c7605; o_ct_valid at T+21.
//  - FIPS-197 C.1: key 000102..0f, pt 00112233..eeff -> ct 69c4e0d86a7b0430d8cdb78070b4c55a.
//    o_last_round high only on the 10th issue.
//  - ROUND_LAT=3: same vector -> same ct at T+41. o_round_in/o_round_key stable across WAIT.
//  - Backpressure: hold i_ct_ready=0 for 5 cycles -> ct held stable, o_start_ready=0.
//    Back-to-back request is accepted only after the handshake.
//  - i_start_valid while busy -> ignored, no corruption. i_rst at round 5 -> next cycle
//    IDLE, all outputs 0. A fresh request then yields the correct ct.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared FSM encoding and GF(2^8) helpers for the AES round sequencer
package aes_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_e;
    localparam logic [7:0] RCON_INIT = 8'h01;
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? p ^ x : p;
            x = xtime(x);
        end
        return p;
    endfunction
    // inverse as b^254, then the affine map; zero maps to zero before the affine step
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] sq, inv;
        sq = b;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction
    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction
    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction
endpackage

// File: rtl/aes_key_step.sv
// aes_key_step: one step of the AES-128 key schedule
module aes_key_step
    import aes_pkg::*;
(
    input  logic [127:0] key,
    input  logic [7:0]   rcon,
    output logic [127:0] next_key
);
    logic [31:0] w0, w1, w2, w3;
    assign w0 = key[127:96] ^ sub_word(rot_word(key[31:0])) ^ {rcon, 24'h0};
    assign w1 = key[95:64] ^ w0;
    assign w2 = key[63:32] ^ w1;
    assign w3 = key[31:0] ^ w2;
    assign next_key = {w0, w1, w2, w3};
endmodule

// File: rtl/aes_enc_round_sequencer.sv
// aes_enc_round_sequencer: iterative AES-128 controller driving an external round datapath
module aes_enc_round_sequencer
    import aes_pkg::*;
#(
    parameter int NR = 10,
    parameter int ROUND_LAT = 1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start_valid,
    output logic         o_start_ready,
    input  logic [127:0] i_plaintext,
    input  logic [127:0] i_key,
    output logic         o_round_valid,
    output logic [127:0] o_round_in,
    output logic [127:0] o_round_key,
    output logic         o_last_round,
    input  logic [127:0] i_round_out,
    output logic         o_ct_valid,
    input  logic         i_ct_ready,
    output logic [127:0] o_ciphertext,
    output logic         o_busy
);
    localparam int RW = $clog2(NR + 1);
    localparam int LW = ROUND_LAT > 1 ? $clog2(ROUND_LAT) : 1;
    state_e state;
    logic [127:0] state_reg, key_reg, ks_out;
    logic [7:0] rcon;
    logic [RW-1:0] round;
    logic [LW-1:0] lat_cnt;
    logic last, run;
    // the single key-step instance serves both the first round key (from i_key) and later steps
    aes_key_step u_key_step (
        .key(state == IDLE ? i_key : key_reg),
        .rcon(state == IDLE ? RCON_INIT : rcon),
        .next_key(ks_out)
    );
    assign last = round == RW'(NR);
    assign run = state == ISSUE || state == WAIT;
    assign o_start_ready = state == IDLE;
    assign o_busy = state != IDLE;
    assign o_round_valid = state == ISSUE;
    assign o_round_in = run ? state_reg : '0;
    assign o_round_key = run ? key_reg : '0;
    assign o_last_round = run && last;
    assign o_ct_valid = state == DONE;
    assign o_ciphertext = o_ct_valid ? state_reg : '0;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
            state_reg <= '0;
            key_reg <= '0;
            rcon <= RCON_INIT;
            round <= '0;
            lat_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (i_start_valid) begin
                    state_reg <= i_plaintext ^ i_key;
                    key_reg <= ks_out;
                    rcon <= xtime(RCON_INIT);
                    round <= RW'(1);
                    state <= ISSUE;
                end
                ISSUE: begin
                    lat_cnt <= LW'(ROUND_LAT - 1);
                    state <= WAIT;
                end
                WAIT: if (lat_cnt != '0) begin
                    lat_cnt <= lat_cnt - 1'b1;
                end else begin
                    state_reg <= i_round_out;
                    if (last) begin
                        state <= DONE;
                    end else begin
                        round <= round + 1'b1;
                        key_reg <= ks_out;
                        rcon <= xtime(rcon);
                        state <= ISSUE;
                    end
                end
                DONE: if (i_ct_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
